diff_commit_packer: RTL and testbench

- Upstream feeder of the difftest bridge.
- Takes up to 4 retirement records per cycle from the ROB commit port; lanes may be sparse.
- Compacts valid lanes into contiguous difftest slots 0..3 and registers them.
- Keeps a shadow 32-entry GPR file updated from committed writes, so the bridge sees commit records and architectural register state aligned in the same cycle.

---
 rtl/diff_commit_packer.sv | 181 ++++++++++++++++++
 tb/tb_diff_commit_packer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/diff_commit_packer.sv
// Compacts up to four sparse ROB commit lanes into contiguous difftest slots and keeps a shadow GPR file.
// Optional idle-commit watchdog enabled by defining DIFF_COMMIT_WATCHDOG_EN.
module diff_commit_packer #(
  parameter int unsigned CORE_ID = 0
`ifdef DIFF_COMMIT_WATCHDOG_EN
  , parameter int unsigned WD_TIMEOUT = 65536
`endif
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic [3:0]            in_valid,
  input  logic [3:0][63:0]      in_pc,
  input  logic [3:0][31:0]      in_instr,
  input  logic [3:0]            in_skip,
  input  logic [3:0]            in_tlbfill,
  input  logic [3:0][4:0]       in_tlbfill_idx,
  input  logic [3:0]            in_cnt,
  input  logic [3:0][63:0]      in_timer,
  input  logic [3:0]            in_wen,
  input  logic [3:0][4:0]       in_wdest,
  input  logic [3:0][63:0]      in_wdata,
  input  logic [3:0]            in_csr_rstat,
  input  logic [3:0][31:0]      in_csr_data,
  output logic [7:0]            coreid,
  output logic [3:0][7:0]       out_index,
  output logic [3:0]            out_valid,
  output logic [3:0][63:0]      out_pc,
  output logic [3:0][31:0]      out_instr,
  output logic [3:0]            out_skip,
  output logic [3:0]            out_tlbfill,
  output logic [3:0][4:0]       out_tlbfill_idx,
  output logic [3:0]            out_cnt,
  output logic [3:0][63:0]      out_timer,
  output logic [3:0]            out_wen,
  output logic [3:0][7:0]       out_wdest,
  output logic [3:0][63:0]      out_wdata,
  output logic [3:0]            out_csr_rstat,
  output logic [3:0][31:0]      out_csr_data,
  output logic [31:0][63:0]     gpr,
  output logic [63:0]           commit_cnt,
  output logic                  wd_hit
);

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
    logic        skip;
    logic        tlbfill;
    logic [4:0]  tlbfill_idx;
    logic        cnt;
    logic [63:0] timer;
    logic        wen;
    logic [4:0]  wdest;
    logic [63:0] wdata;
    logic        csr_rstat;
    logic [31:0] csr_data;
  } slot_t;

  slot_t [3:0]      slot_d, slot_q;
  logic  [3:0]      valid_d, valid_q;
  logic  [2:0]      pop;
  logic  [3:0][7:0] index_q;
  logic  [31:0][63:0] gpr_d, gpr_q;
  logic  [63:0]     commit_cnt_d, commit_cnt_q;

  // NOTE: pop is a running slot pointer; blocking updates inside always_comb let each
  // lane see the count of valid lanes below it. Every output gets a default first, so no latch.
  always_comb begin
    slot_d  = '0;
    valid_d = '0;
    pop     = '0;
    for (int lane = 0; lane < 4; lane++) begin
      if (in_valid[lane]) begin
        slot_d[pop[1:0]].pc          = in_pc[lane];
        slot_d[pop[1:0]].instr       = in_instr[lane];
        slot_d[pop[1:0]].skip        = in_skip[lane];
        slot_d[pop[1:0]].tlbfill     = in_tlbfill[lane];
        slot_d[pop[1:0]].tlbfill_idx = in_tlbfill_idx[lane];
        slot_d[pop[1:0]].cnt         = in_cnt[lane];
        slot_d[pop[1:0]].timer       = in_timer[lane];
        slot_d[pop[1:0]].wen         = in_wen[lane] && (in_wdest[lane] != 5'd0);
        slot_d[pop[1:0]].wdest       = in_wdest[lane];
        slot_d[pop[1:0]].wdata       = in_wdata[lane];
        slot_d[pop[1:0]].csr_rstat   = in_csr_rstat[lane];
        slot_d[pop[1:0]].csr_data    = in_csr_data[lane];
        valid_d[pop[1:0]]            = 1'b1;
        pop                          = pop + 3'd1;
      end
    end
  end

  // Ascending lane order makes the highest valid lane win on same-register writes.
  always_comb begin
    gpr_d = gpr_q;
    for (int lane = 0; lane < 4; lane++) begin
      if (in_valid[lane] && in_wen[lane] && (in_wdest[lane] != 5'd0)) begin
        gpr_d[in_wdest[lane]] = in_wdata[lane];
      end
    end
    gpr_d[0] = '0;
  end

  assign commit_cnt_d = commit_cnt_q + 64'(pop);

  // NOTE: the shadow GPR file is reset as a flop array (not a RAM) because the bridge
  // must see architectural zeros immediately after reset.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      slot_q       <= '0;
      valid_q      <= '0;
      index_q      <= '0;
      gpr_q        <= '0;
      commit_cnt_q <= '0;
    end else begin
      slot_q       <= slot_d;
      valid_q      <= valid_d;
      index_q      <= {8'd3, 8'd2, 8'd1, 8'd0};
      gpr_q        <= gpr_d;
      commit_cnt_q <= commit_cnt_d;
    end
  end

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      out_pc[k]          = slot_q[k].pc;
      out_instr[k]       = slot_q[k].instr;
      out_skip[k]        = slot_q[k].skip;
      out_tlbfill[k]     = slot_q[k].tlbfill;
      out_tlbfill_idx[k] = slot_q[k].tlbfill_idx;
      out_cnt[k]         = slot_q[k].cnt;
      out_timer[k]       = slot_q[k].timer;
      out_wen[k]         = slot_q[k].wen;
      out_wdest[k]       = {3'b000, slot_q[k].wdest};
      out_wdata[k]       = slot_q[k].wdata;
      out_csr_rstat[k]   = slot_q[k].csr_rstat;
      out_csr_data[k]    = slot_q[k].csr_data;
    end
  end

  assign coreid     = 8'(CORE_ID);
  assign out_index  = index_q;
  assign out_valid  = valid_q;
  assign gpr        = gpr_q;
  assign commit_cnt = commit_cnt_q;

`ifdef DIFF_COMMIT_WATCHDOG_EN
  localparam logic [31:0] WdLimit = 32'(WD_TIMEOUT);

  logic [31:0] idle_d, idle_q;
  logic        wd_hit_d, wd_hit_q;

  // Idle counter saturates at the limit; the hit flag is sticky until reset.
  always_comb begin
    idle_d   = idle_q;
    wd_hit_d = wd_hit_q;
    if (in_valid != 4'd0) begin
      idle_d = '0;
    end else if (idle_q != WdLimit) begin
      idle_d = idle_q + 32'd1;
    end
    if (idle_d == WdLimit) begin
      wd_hit_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      idle_q   <= '0;
      wd_hit_q <= 1'b0;
    end else begin
      idle_q   <= idle_d;
      wd_hit_q <= wd_hit_d;
    end
  end

  assign wd_hit = wd_hit_q;
`else
  assign wd_hit = 1'b0;
`endif

endmodule

// File: tb/tb_diff_commit_packer.sv
// Directed self-checking bench for diff_commit_packer; watchdog steps follow DIFF_COMMIT_WATCHDOG_EN.
module tb_diff_commit_packer;

  logic               clock;
  logic               resetn;
  logic [3:0]         in_valid;
  logic [3:0][63:0]   in_pc;
  logic [3:0][31:0]   in_instr;
  logic [3:0]         in_skip;
  logic [3:0]         in_tlbfill;
  logic [3:0][4:0]    in_tlbfill_idx;
  logic [3:0]         in_cnt;
  logic [3:0][63:0]   in_timer;
  logic [3:0]         in_wen;
  logic [3:0][4:0]    in_wdest;
  logic [3:0][63:0]   in_wdata;
  logic [3:0]         in_csr_rstat;
  logic [3:0][31:0]   in_csr_data;
  logic [7:0]         coreid;
  logic [3:0][7:0]    out_index;
  logic [3:0]         out_valid;
  logic [3:0][63:0]   out_pc;
  logic [3:0][31:0]   out_instr;
  logic [3:0]         out_skip;
  logic [3:0]         out_tlbfill;
  logic [3:0][4:0]    out_tlbfill_idx;
  logic [3:0]         out_cnt;
  logic [3:0][63:0]   out_timer;
  logic [3:0]         out_wen;
  logic [3:0][7:0]    out_wdest;
  logic [3:0][63:0]   out_wdata;
  logic [3:0]         out_csr_rstat;
  logic [3:0][31:0]   out_csr_data;
  logic [31:0][63:0]  gpr;
  logic [63:0]        commit_cnt;
  logic               wd_hit;

  int errors = 0;
  int checks = 0;

  diff_commit_packer #(
    .CORE_ID(0)
`ifdef DIFF_COMMIT_WATCHDOG_EN
    , .WD_TIMEOUT(16)
`endif
  ) dut (
    .clock(clock), .resetn(resetn),
    .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr), .in_skip(in_skip),
    .in_tlbfill(in_tlbfill), .in_tlbfill_idx(in_tlbfill_idx), .in_cnt(in_cnt),
    .in_timer(in_timer), .in_wen(in_wen), .in_wdest(in_wdest), .in_wdata(in_wdata),
    .in_csr_rstat(in_csr_rstat), .in_csr_data(in_csr_data),
    .coreid(coreid), .out_index(out_index), .out_valid(out_valid), .out_pc(out_pc),
    .out_instr(out_instr), .out_skip(out_skip), .out_tlbfill(out_tlbfill),
    .out_tlbfill_idx(out_tlbfill_idx), .out_cnt(out_cnt), .out_timer(out_timer),
    .out_wen(out_wen), .out_wdest(out_wdest), .out_wdata(out_wdata),
    .out_csr_rstat(out_csr_rstat), .out_csr_data(out_csr_data),
    .gpr(gpr), .commit_cnt(commit_cnt), .wd_hit(wd_hit)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic clear_inputs();
    in_valid = '0; in_pc = '0; in_instr = '0; in_skip = '0; in_tlbfill = '0;
    in_tlbfill_idx = '0; in_cnt = '0; in_timer = '0; in_wen = '0; in_wdest = '0;
    in_wdata = '0; in_csr_rstat = '0; in_csr_data = '0;
  endtask

  initial begin
    clear_inputs();
    resetn = 1'b1;
    #1 resetn = 1'b0;
    #11;
    check("rst_out_valid", 64'(out_valid), 64'h0);
    check("rst_commit_cnt", commit_cnt, 64'h0);
    check("rst_out_index", 64'(out_index), 64'h0);
    check("rst_gpr5", gpr[5], 64'h0);
    check("rst_wd_hit", 64'(wd_hit), 64'h0);
    check("coreid", 64'(coreid), 64'h0);

    // Sparse lanes 1 and 3; invalid lanes carry junk including a write to r7.
    @(negedge clock);
    resetn = 1'b1;
    in_valid = 4'b1010;
    in_pc[0] = 64'hbad0; in_wen[0] = 1'b1; in_wdest[0] = 5'd7; in_wdata[0] = 64'hbad;
    in_pc[1] = 64'h1c000004; in_instr[1] = 32'h02800421; in_wen[1] = 1'b1;
    in_wdest[1] = 5'd3; in_wdata[1] = 64'h1111; in_timer[1] = 64'h77;
    in_pc[2] = 64'hbad2; in_wen[2] = 1'b1; in_wdest[2] = 5'd7; in_wdata[2] = 64'hbad;
    in_pc[3] = 64'h1c00000c; in_instr[3] = 32'h4c000020; in_skip[3] = 1'b1;
    in_tlbfill[3] = 1'b1; in_tlbfill_idx[3] = 5'd9; in_csr_rstat[3] = 1'b1;
    in_csr_data[3] = 32'hcafe;
    @(negedge clock);
    check("sparse_out_valid", 64'(out_valid), 64'h3);
    check("sparse_pc0", out_pc[0], 64'h1c000004);
    check("sparse_pc1", out_pc[1], 64'h1c00000c);
    check("sparse_instr1", 64'(out_instr[1]), 64'h4c000020);
    check("sparse_timer0", out_timer[0], 64'h77);
    check("sparse_skip", 64'(out_skip), 64'h2);
    check("sparse_tlbfill_idx1", 64'(out_tlbfill_idx[1]), 64'd9);
    check("sparse_csr_data1", 64'(out_csr_data[1]), 64'hcafe);
    check("sparse_wen", 64'(out_wen), 64'h1);
    check("sparse_wdest0", 64'(out_wdest[0]), 64'd3);
    check("sparse_pc2_zero", out_pc[2], 64'h0);
    check("sparse_wdata3_zero", out_wdata[3], 64'h0);
    check("sparse_index", 64'(out_index), 64'h03020100);
    check("sparse_gpr3", gpr[3], 64'h1111);
    check("sparse_gpr7_ignored", gpr[7], 64'h0);
    check("sparse_commit_cnt", commit_cnt, 64'd2);

    // Lanes 0,2,3 write r5; invalid lane 1 also targets r5.
    clear_inputs();
    in_valid = 4'b1101;
    in_wen = 4'b1111;
    in_wdest = {5'd5, 5'd5, 5'd5, 5'd5};
    in_wdata = {64'h33, 64'h22, 64'h99, 64'h11};
    @(negedge clock);
    check("same_out_valid", 64'(out_valid), 64'h7);
    check("same_gpr5", gpr[5], 64'h33);
    check("same_wdata2", out_wdata[2], 64'h33);
    check("same_wdata1", out_wdata[1], 64'h22);
    check("same_wdata0", out_wdata[0], 64'h11);
    check("same_commit_cnt", commit_cnt, 64'd5);

    // Write to r0 must be suppressed.
    clear_inputs();
    in_valid = 4'b0001;
    in_wen[0] = 1'b1; in_wdest[0] = 5'd0; in_wdata[0] = 64'hdead;
    @(negedge clock);
    check("r0_gpr0", gpr[0], 64'h0);
    check("r0_out_wen", 64'(out_wen), 64'h0);
    check("r0_out_valid", 64'(out_valid), 64'h1);
    check("r0_commit_cnt", commit_cnt, 64'd6);

    // Idle cycle clears slots but keeps architectural state.
    clear_inputs();
    @(negedge clock);
    check("idle_out_valid", 64'(out_valid), 64'h0);
    check("idle_wdata0", out_wdata[0], 64'h0);
    check("idle_gpr5_hold", gpr[5], 64'h33);
    check("idle_commit_cnt", commit_cnt, 64'd6);

    // Reset mid-stream, asserted between edges.
    in_valid = 4'b1111;
    in_pc = {64'h40, 64'h30, 64'h20, 64'h10};
    @(posedge clock);
    #2 resetn = 1'b0;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'h0);
    check("midrst_pc0", out_pc[0], 64'h0);
    check("midrst_commit_cnt", commit_cnt, 64'h0);
    check("midrst_gpr3", gpr[3], 64'h0);
    @(negedge clock);
    resetn = 1'b1;
    in_valid = 4'b0011;
    @(negedge clock);
    check("postrst_commit_cnt", commit_cnt, 64'd2);
    check("postrst_pc1", out_pc[1], 64'h20);

    // Full group across the 64-bit wrap point.
    force dut.commit_cnt_q = 64'hFFFF_FFFF_FFFF_FFFC;
    in_valid = 4'b1111;
    #1 release dut.commit_cnt_q;
    @(negedge clock);
    check("wrap_commit_cnt", commit_cnt, 64'h0);
    check("wrap_out_valid", 64'(out_valid), 64'hf);
    check("wrap_pc3", out_pc[3], 64'h40);
    check("wrap_index", 64'(out_index), 64'h03020100);

    clear_inputs();
`ifdef DIFF_COMMIT_WATCHDOG_EN
    repeat (15) @(negedge clock);
    check("wd_idle15", 64'(wd_hit), 64'h0);
    @(negedge clock);
    check("wd_idle16", 64'(wd_hit), 64'h1);
    in_valid = 4'b0001;
    @(negedge clock);
    check("wd_sticky", 64'(wd_hit), 64'h1);
    clear_inputs();
`else
    repeat (20) @(negedge clock);
    check("wd_disabled", 64'(wd_hit), 64'h0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
